// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM state register type
//   ST_IDLE/SHIFT/DONE : state encodings
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtractor cells.
// half_subtractor : a, b          -> d = a - b, bout (borrow out)
// full_subtractor : A, B, Bin     -> D = A - B - Bin, Bout (borrow out)
// The full subtractor chains two half subtractors; a borrow out of
// either stage means the slice borrows.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .a    (A),
        .b    (B),
        .d    (d1),
        .bout (b1)
    );

    half_subtractor u_hs1 (
        .a    (d1),
        .b    (Bin),
        .d    (D),
        .bout (b2)
    );

    assign Bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, D = A - B (mod 2^WIDTH), LSB first.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   start         : request, only honoured in IDLE
//   A, B          : operands, captured on the accepting edge
//   busy          : operation in progress
//   done          : one-cycle pulse when D/bout have just been updated
//   D, bout       : registered difference and final borrow (A < B)
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | one bit processed per clock, WIDTH clocks total
// ST_DONE  | results valid and done pulsed; returns to IDLE
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    count;
    logic             br;
    logic             d_bit;
    logic             b_next;

    full_subtractor u_slice (
        .A    (sa[0]),
        .B    (sb[0]),
        .Bin  (br),
        .D    (d_bit),
        .Bout (b_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            count <= '0;
            br    <= 1'b0;
            D     <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        res   <= '0;
                        count <= '0;
                        br    <= 1'b0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    br    <= b_next;
                    res   <= {d_bit, res[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    count <= count + CW'(1);
                    // The last bit goes straight into D so the result is
                    // complete in the same edge that leaves SHIFT.
                    if (count == LAST) begin
                        D     <= {d_bit, res[WIDTH-1:1]};
                        bout  <= b_next;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;
    localparam int LAT = W + 1;
    localparam int TMO = 20;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         bout;

    exp_t q[$];
    int   total;
    int   bad;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] diff;
        diff = a - b;
        e.d = diff;
        e.b = (a < b);
        return e;
    endfunction

    // Called at a negedge: presents the operands with start for one edge.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a;
        B = b;
        start = 1'b1;
        q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or at the bound);
    // lat counts negedges after the accepting edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, D, bout} !== '0) begin
            bad++;
            $display("FAIL reset_vals: got busy=%b done=%b D=%0d bout=%b want all 0", busy, done, D, bout);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({busy, done, D, bout} !== '0) begin
                bad++;
                $display("FAIL idle_hold[%0d]: got busy=%b done=%b D=%0d bout=%b want all 0", i, busy, done, D, bout);
            end
        end
    endtask

    task automatic test_ops(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat;
        exp_t e;
        drive_start(a, b);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy: got %b want 1", name, busy);
        end
        wait_done(lat);
        e = q.pop_front();
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
        end
        total++;
        if (D !== e.d || bout !== e.b) begin
            bad++;
            $display("FAIL %s_result: got D=%0d bout=%b want D=%0d bout=%b", name, D, bout, e.d, e.b);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int   seen;
        int   since;
        int   cyc;
        logic prev_busy;
        exp_t e;
        seen = 0;
        since = 0;
        cyc = 0;
        prev_busy = 1'b0;
        A = 4'd5;
        B = 4'd2;
        start = 1'b1;
        while (seen < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            since++;
            if (busy === 1'b1 && prev_busy === 1'b0)
                q.push_back(model(4'd5, 4'd2));
            prev_busy = busy;
            if (done === 1'b1) begin
                e = q.pop_front();
                total++;
                if (D !== e.d || bout !== e.b) begin
                    bad++;
                    $display("FAIL b2b_result[%0d]: got D=%0d bout=%b want D=%0d bout=%b", seen, D, bout, e.d, e.b);
                end
                if (seen > 0) begin
                    total++;
                    if (since !== W + 2) begin
                        bad++;
                        $display("FAIL b2b_period[%0d]: got %0d want %0d", seen, since, W + 2);
                    end
                end
                since = 0;
                seen++;
            end
            if (busy === 1'b1) begin
                A = W'($urandom);
                B = W'($urandom);
            end else begin
                A = 4'd5;
                B = 4'd2;
            end
        end
        start = 1'b0;
        total++;
        if (seen !== 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d done pulses want 3", seen);
        end
        q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        drive_start(4'd9, 4'd3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        total++;
        if ({busy, done, D, bout} !== '0) begin
            bad++;
            $display("FAIL midrst_vals: got busy=%b done=%b D=%0d bout=%b want all 0", busy, done, D, bout);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_nodone: got done pulse want none");
        end
        test_ops("midrst_after", 4'd7, 4'd2);
    endtask

    task automatic test_exhaustive();
        int   lat;
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive_start(W'(a), W'(b));
                A = W'($urandom);
                B = W'($urandom);
                wait_done(lat);
                e = q.pop_front();
                total++;
                if (lat !== LAT || D !== e.d || bout !== e.b) begin
                    bad++;
                    $display("FAIL exh_%0d_%0d: got lat=%0d D=%0d bout=%b want lat=%0d D=%0d bout=%b",
                             a, b, lat, D, bout, LAT, e.d, e.b);
                end
                @(negedge clk);
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL exh_pulse_%0d_%0d: got done=%b want 0", a, b, done);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_ops("a9_b3", 4'd9, 4'd3);
        test_ops("a3_b9", 4'd3, 4'd9);
        test_ops("a0_b1", 4'd0, 4'd1);
        test_ops("a15_b15", 4'd15, 4'd15);
        test_ops("a15_b0", 4'd15, 4'd0);
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
